fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The parameter PC_INIT SHALL default to 32'h0 and set the reset fetch address.
REQ-002 The parameter DEPTH SHALL default to 4 and set the number of queue entries (power of 2, >= 2).
REQ-003 CLK SHALL be a 1-bit input: the single clock; all state updates on posedge.
REQ-004 nRST SHALL be a 1-bit input: reset, asynchronous and active-low.
REQ-005 ihit SHALL be a 1-bit input: instruction cache returned imemload for imemaddr this cycle.
REQ-006 imemload SHALL be a 32-bit input: fetched instruction word.
REQ-007 imemREN SHALL be a 1-bit output: instruction read request.
REQ-008 imemaddr SHALL be a 32-bit output: current fetch PC.
REQ-009 redirect SHALL be a 1-bit input: branch/jump taken; flush and refetch.
REQ-010 redirect_pc SHALL be a 32-bit input: new fetch target.
REQ-011 halt SHALL be a 1-bit input: sticky processor halt.
REQ-012 deq SHALL be a 1-bit input: consumer accepts the head entry.
REQ-013 inst_valid SHALL be a 1-bit output: head entry is valid.
REQ-014 inst SHALL be a 32-bit output: head instruction.
REQ-015 inst_pc SHALL be a 32-bit output: head entry's PC.
REQ-016 count SHALL be a $clog2(DEPTH+1)-bit output: current occupancy.

Function
REQ-017 imemREN SHALL equal (count != DEPTH) & ~halt & ~redirect, combinationally.
REQ-018 imemaddr SHALL equal fetch_pc, a registered value.
REQ-019 On ihit & imemREN, the entry {fetch_pc, imemload} SHALL be written at wr_ptr, and wr_ptr and fetch_pc += 4 SHALL both advance at the clock edge.
REQ-020 An ihit while imemREN is low SHALL be ignored.
REQ-021 inst_valid SHALL be (count != 0); inst and inst_pc SHALL show the entry at rd_ptr.
REQ-022 There SHALL be no bypass: an instruction becomes visible the cycle after its ihit.
REQ-023 deq & inst_valid SHALL advance rd_ptr; deq while empty SHALL be ignored.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and move both pointers.
REQ-025 Pointers SHALL be $clog2(DEPTH) bits wide and SHALL wrap modulo DEPTH.
REQ-026 Adding 4 to fetch_pc SHALL wrap modulo 2^32.
REQ-027 redirect SHALL take priority over all other events:
- count, rd_ptr and wr_ptr SHALL be cleared to 0;
- fetch_pc SHALL load {redirect_pc[31:2], 2'b00};
- a concurrent ihit and deq SHALL be discarded.
REQ-028 While halt is high, fetch_pc SHALL not advance and no push SHALL occur.
REQ-029 While halt is high, queued entries SHALL remain dequeueable, and redirect SHALL still flush.
REQ-030 When full (count == DEPTH), imemREN SHALL be low and fetch_pc SHALL hold.
REQ-031 When full and deq is asserted, imemREN SHALL rise in the following cycle.

Reset
REQ-032 While nRST is low, fetch_pc SHALL be PC_INIT, and count, rd_ptr and wr_ptr SHALL be 0.
REQ-033 While nRST is low, inst_valid SHALL be 0, and inst and inst_pc SHALL read the zeroed storage.
REQ-034 Reset asserted mid-operation SHALL discard all entries immediately (asynchronously), with no partial push.
REQ-035 Storage entries SHALL reset to 0.
REQ-036 The first request after reset SHALL be imemREN=1 with imemaddr=PC_INIT in the first cycle after nRST deasserts.

Structure
REQ-037 fetch_entry_t (a struct of word_t pc and word_t instr) SHALL be added to cpu_types_pkg.
REQ-038 word_t SHALL be reused from cpu_types_pkg.
REQ-039 fetch_queue SHALL instantiate one sub-module, fetch_fifo (parametrised DEPTH, storing fetch_entry_t, with flush, push, pop, count), while fetch_pc and the request logic stay in fetch_queue.
REQ-040 No new constants SHALL be added beyond the PC increment 32'd4, which is local.

Verification
REQ-041 Reset release with PC_INIT=0 and ihit every cycle, no deq -> imemaddr 0, 4, 8, 12; count reaches 4; imemREN drops; fetch_pc holds at 16.
REQ-042 Full queue, single deq -> inst_pc=0 popped; count 3; next cycle imemREN=1 and imemaddr=16.
REQ-043 Queue holding PCs 0 and 4, with redirect=1, redirect_pc=32'h103 together with ihit and deq -> next cycle count=0, inst_valid=0, imemaddr=32'h100; the ihit data is not enqueued.
REQ-044 Steady ihit and deq every cycle at count=1 -> count stays 1 and inst_pc increments by 4 each cycle across a pointer wrap (DEPTH=4, 10 cycles).
REQ-045 halt=1 with 2 entries queued -> imemREN=0 and imemaddr frozen; two deqs drain to count=0; further deq is ignored.
REQ-046 fetch_pc=32'hFFFFFFFC with ihit, and also nRST pulsed low mid-stream with count=3 -> wraparound: next imemaddr=0; reset: outputs are at reset values immediately, before the next edge.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: the machine word and the fetch queue entry.
// Type definitions only; no logic, no latency.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetch entries; a push is visible at head one cycle later (no bypass).
// A push when full or a pop when empty is dropped; flush empties the buffer in one cycle.
module fetch_fifo
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               flush,
  input  logic               push,
  input  fetch_entry_t       push_entry,
  input  logic               pop,
  output fetch_entry_t       head,
  output logic [CNT_W-1:0]   count
);

  fetch_entry_t      mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              full;
  logic              empty;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers are exactly log2(DEPTH) bits, so incrementing wraps modulo DEPTH.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues sequential I-cache reads and buffers results in order.
// Fetched words reach the head one cycle after ihit; requests stop while full, halted or redirecting.
module fetch_queue
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0,
  parameter int          DEPTH   = 4,
  localparam int         CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               ihit,
  input  logic [31:0]        imemload,
  output logic               imemREN,
  output logic [31:0]        imemaddr,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               halt,
  input  logic               deq,
  output logic               inst_valid,
  output logic [31:0]        inst,
  output logic [31:0]        inst_pc,
  output logic [CNT_W-1:0]   count
);

  localparam word_t PC_INC = 32'd4;

  word_t        fetch_pc;
  word_t        redirect_target;
  logic         push;
  logic         pop;
  fetch_entry_t entry;
  fetch_entry_t head;

  assign imemREN  = (count != CNT_W'(DEPTH)) & ~halt & ~redirect;
  assign imemaddr = fetch_pc;

  // Redirect wins over everything: a same-cycle ihit or deq must not touch the queue.
  assign push = ihit & imemREN;
  assign pop  = deq & ~redirect;

  // Word-align the target by clearing the two byte-offset bits.
  assign redirect_target = (redirect_pc >> 2) << 2;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_pc <= PC_INIT;
    end else if (redirect) begin
      fetch_pc <= redirect_target;
    end else if (push) begin
      fetch_pc <= fetch_pc + PC_INC;
    end
  end

  assign entry = '{pc: fetch_pc, instr: imemload};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK        (CLK),
    .nRST       (nRST),
    .flush      (redirect),
    .push       (push),
    .push_entry (entry),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

  assign inst_valid = (count != '0);
  assign inst       = head.instr;
  assign inst_pc    = head.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and random stimulus for fetch_queue against a queue-based reference model.
module tb_fetch_queue;

  localparam int          DEPTH   = 4;
  localparam int          CNT_W   = $clog2(DEPTH + 1);
  localparam logic [31:0] PC_INIT = 32'h0;

  logic             CLK;
  logic             nRST;
  logic             ihit;
  logic [31:0]      imemload;
  logic             imemREN;
  logic [31:0]      imemaddr;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             halt;
  logic             deq;
  logic             inst_valid;
  logic [31:0]      inst;
  logic [31:0]      inst_pc;
  logic [CNT_W-1:0] count;

  fetch_queue #(
    .PC_INIT (PC_INIT),
    .DEPTH   (DEPTH)
  ) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .ihit        (ihit),
    .imemload    (imemload),
    .imemREN     (imemREN),
    .imemaddr    (imemaddr),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .deq         (deq),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .count       (count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mpc;
  int          passed = 0;
  int          total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_model();
    logic exp_ren;
    exp_ren = (mq.size() != DEPTH) && !halt && !redirect;
    chk("m_ren", 32'(imemREN), 32'(exp_ren));
    chk("m_addr", imemaddr, mpc);
    chk("m_valid", 32'(inst_valid), 32'(mq.size() != 0));
    chk("m_count", 32'(count), 32'(mq.size()));
    if (mq.size() != 0) begin
      chk("m_inst", inst, mq[0].ins);
      chk("m_inst_pc", inst_pc, mq[0].pc);
    end
  endtask

  // Reference behaviour at a clock edge, from the queue's rules.
  task automatic model_edge();
    logic ren;
    ent_t e;
    ren = (mq.size() != DEPTH) && !halt && !redirect;
    if (redirect) begin
      mq.delete();
      mpc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (deq && mq.size() > 0) mq.delete(0);
      if (ihit && ren) begin
        e.pc  = mpc;
        e.ins = imemload;
        mq.push_back(e);
        mpc = mpc + 32'd4;
      end
    end
  endtask

  task automatic step(input logic ih, input logic [31:0] ld, input logic dq,
                      input logic rd, input logic [31:0] rp, input logic hl);
    ihit = ih; imemload = ld; deq = dq; redirect = rd; redirect_pc = rp; halt = hl;
    #1;
    check_model();
    @(posedge CLK);
    model_edge();
    #1;
    ihit = 1'b0; deq = 1'b0; redirect = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; ihit = 1'b0; imemload = '0; deq = 1'b0;
    redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    mpc = PC_INIT;

    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_addr", imemaddr, PC_INIT);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    chk("first_ren", 32'(imemREN), 32'd1);
    chk("first_addr", imemaddr, PC_INIT);
    @(posedge CLK);
    #1;

    // Fill with ihit every cycle and no deq.
    for (int i = 0; i < 4; i++) begin
      chk("fill_addr", imemaddr, 32'(4 * i));
      step(1'b1, $urandom, 1'b0, 1'b0, '0, 1'b0);
    end
    chk("full_count", 32'(count), 32'd4);
    chk("full_ren", 32'(imemREN), 32'd0);
    chk("full_addr", imemaddr, 32'd16);
    step(1'b1, $urandom, 1'b0, 1'b0, '0, 1'b0);
    chk("full_hold_addr", imemaddr, 32'd16);
    chk("full_hold_count", 32'(count), 32'd4);

    // Single deq from full.
    chk("deq_head_pc", inst_pc, 32'd0);
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    chk("deq_count", 32'(count), 32'd3);
    chk("deq_ren", 32'(imemREN), 32'd1);
    chk("deq_addr", imemaddr, 32'd16);

    // Redirect beats concurrent ihit and deq.
    step(1'b0, '0, 1'b0, 1'b1, 32'h0, 1'b0);
    step(1'b1, $urandom, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, $urandom, 1'b0, 1'b0, '0, 1'b0);
    chk("pre_redir_count", 32'(count), 32'd2);
    chk("pre_redir_pc", inst_pc, 32'd0);
    step(1'b1, $urandom, 1'b1, 1'b1, 32'h103, 1'b0);
    chk("redir_count", 32'(count), 32'd0);
    chk("redir_valid", 32'(inst_valid), 32'd0);
    chk("redir_addr", imemaddr, 32'h100);

    // Push and pop every cycle at count 1, across a pointer wrap.
    step(1'b1, $urandom, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("pp_count", 32'(count), 32'd1);
      chk("pp_inst_pc", inst_pc, 32'h100 + 32'(4 * i));
      step(1'b1, $urandom, 1'b1, 1'b0, '0, 1'b0);
    end
    chk("pp_final_count", 32'(count), 32'd1);

    // Halt: no fetch, queue still drains, redirect still flushes.
    step(1'b0, '0, 1'b0, 1'b1, 32'h200, 1'b0);
    step(1'b1, $urandom, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, $urandom, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, $urandom, 1'b0, 1'b0, '0, 1'b1);
    chk("halt_ren", 32'(imemREN), 32'd0);
    chk("halt_addr", imemaddr, 32'h208);
    chk("halt_count", 32'(count), 32'd2);
    step(1'b1, $urandom, 1'b1, 1'b0, '0, 1'b1);
    step(1'b1, $urandom, 1'b1, 1'b0, '0, 1'b1);
    chk("halt_drain_count", 32'(count), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    chk("halt_empty_deq_count", 32'(count), 32'd0);
    chk("halt_empty_deq_addr", imemaddr, 32'h208);
    step(1'b0, '0, 1'b0, 1'b1, 32'h300, 1'b1);
    chk("halt_redir_addr", imemaddr, 32'h300);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);

    // PC wrap at the top of the address space.
    step(1'b0, '0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    chk("wrap_pre_addr", imemaddr, 32'hFFFF_FFFC);
    step(1'b1, $urandom, 1'b0, 1'b0, '0, 1'b0);
    chk("wrap_addr", imemaddr, 32'h0);
    chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    step(1'b1, $urandom, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, $urandom, 1'b0, 1'b0, '0, 1'b0);
    chk("mid_pre_count", 32'(count), 32'd3);

    // Asynchronous reset mid-cycle with ihit pending.
    ihit = 1'b1; imemload = $urandom;
    #2;
    nRST = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_valid", 32'(inst_valid), 32'd0);
    chk("arst_inst", inst, 32'd0);
    chk("arst_inst_pc", inst_pc, 32'd0);
    chk("arst_addr", imemaddr, PC_INIT);
    mq.delete();
    mpc = PC_INIT;
    @(negedge CLK);
    ihit = 1'b0;
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 1) == 1,
           $urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 9) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
